lsu_initiator: RTL and testbench

- CPU-side load/store initiator that sits between the execute/memory pipeline stage and a word-organised, handshaked data memory port.
- Accepts one RISC-V load/store request at a time, encoded by funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Converts each request into one or two aligned word transactions with byte strobes, then returns a sign- or zero-extended load result.
- Misaligned accesses that cross a word boundary are split into two beats.

---
 rtl/lsu_initiator.sv | 162 ++++++++++++++++
 tb/tb_lsu_initiator.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_initiator.sv
// Load/store initiator: turns one RISC-V load/store into one or two aligned
// word transactions with byte strobes and returns the extended load result.
module lsu_initiator #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_write;
    logic [2:0]                r_funct3;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [2*DATA_WIDTH-1:0]   r_buf;
    logic [DATA_WIDTH-1:0]     r_resp_rdata;
    logic                      r_resp_err;

    logic                      w_illegal;
    logic [1:0]                w_off;
    logic [2:0]                w_nbytes;
    logic [3:0]                w_mask;
    logic                      w_split;
    logic                      w_hi;
    logic                      w_sx;
    logic [ADDRESS_WIDTH-1:0]  w_base;
    logic [2*DATA_WIDTH-1:0]   w_lane;
    logic [7:0]                w_strb8;
    logic [2*DATA_WIDTH-1:0]   w_buf_next;
    logic [DATA_WIDTH-1:0]     w_shift;
    logic [DATA_WIDTH-1:0]     w_load;

    // Decoded from the live request so an illegal code never reaches REQ0.
    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_write && req_funct3[2]);

    assign w_off  = r_addr[1:0];
    assign w_sx   = ~r_funct3[2];
    assign w_base = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_hi   = (r_state == S_REQ1) || (r_state == S_WAIT1);

    always_comb begin
        w_nbytes = 3'd4;
        w_mask   = 4'b1111;
        case (r_funct3[1:0])
            2'b00: begin w_nbytes = 3'd1; w_mask = 4'b0001; end
            2'b01: begin w_nbytes = 3'd2; w_mask = 4'b0011; end
            default: begin w_nbytes = 3'd4; w_mask = 4'b1111; end
        endcase
    end

    assign w_split = ({1'b0, w_off} + w_nbytes) > 3'd4;
    assign w_lane  = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_strb8 = {4'b0000, w_mask} << w_off;

    // Handshake: a memory beat transfers on a rising edge where mem_valid and
    // mem_ready are both high; beat fields stay stable until then.
    assign req_ready  = (r_state == S_IDLE);
    assign mem_valid  = (r_state == S_REQ0) || (r_state == S_REQ1);
    assign mem_write  = r_write;
    assign mem_addr   = w_hi ? (w_base + ADDRESS_WIDTH'(4)) : w_base;
    assign mem_wdata  = r_write ? (w_hi ? w_lane[2*DATA_WIDTH-1:DATA_WIDTH] : w_lane[DATA_WIDTH-1:0])
                                : '0;
    assign mem_wstrb  = r_write ? (w_hi ? w_strb8[7:4] : w_strb8[3:0]) : 4'b0000;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign dbg_state  = r_state;

    always_comb begin
        w_buf_next = r_buf;
        if (r_state == S_WAIT0 && mem_rvalid) begin
            w_buf_next[DATA_WIDTH-1:0] = mem_rdata;
        end else if (r_state == S_WAIT1 && mem_rvalid) begin
            w_buf_next[2*DATA_WIDTH-1:DATA_WIDTH] = mem_rdata;
        end
    end

    assign w_shift = DATA_WIDTH'(w_buf_next >> {w_off, 3'b000});

    always_comb begin
        w_load = '0;
        case (r_funct3[1:0])
            2'b00:   w_load = {{24{w_sx & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = {{16{w_sx & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_illegal ? S_RESP : S_REQ0;
            S_REQ0:  if (mem_ready) w_next = r_write ? (w_split ? S_REQ1 : S_RESP) : S_WAIT0;
            S_WAIT0: if (mem_rvalid) w_next = w_split ? S_REQ1 : S_RESP;
            S_REQ1:  if (mem_ready) w_next = r_write ? S_RESP : S_WAIT1;
            S_WAIT1: if (mem_rvalid) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_buf   <= w_buf_next;
            if (r_state == S_IDLE && req_valid) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                if (w_illegal) begin
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= '0;
                end
            end else if (w_next == S_RESP && r_state != S_RESP) begin
                // Result is formed from the buffer including the beat captured this edge.
                r_resp_err   <= 1'b0;
                r_resp_rdata <= r_write ? '0 : w_load;
            end
        end
    end

endmodule

// File: tb/tb_lsu_initiator.sv
// Bench for lsu_initiator: byte-level reference model, memory responder and
// a per-cycle compare process, plus directed cases with literal expectations.
module tb_lsu_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_write, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_initiator #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Memory contents: word view for the responder, byte view for the model.
  logic [31:0] wmem [logic [31:0]];
  logic [7:0]  bmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic logic [31:0] wmem_rd(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return init_word(a);
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] a);
    logic [31:0] w;
    if (bmem.exists(a)) return bmem[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*int'(a[1:0]) +: 8];
  endfunction

  task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
    wmem[a] = v;
    for (int i = 0; i < 4; i++) bmem[a + 32'(i)] = v[8*i +: 8];
  endtask

  // Expected traffic: beat = {write, addr, wdata, wstrb}; resp = {err, rdata}.
  logic [68:0] exp_q[$];
  logic [32:0] exp_resp_q[$];
  int          exp_cyc_q[$];
  logic [68:0] obs_q[$];

  bit          busy = 0;
  int          busy_cycles = 0;
  bit          fast_mode = 1;
  int          hold_low = 0;
  int          long_lat = 0;
  int          done_cnt = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;

  task automatic model_push(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input bit chk_lat);
    logic [31:0] wd [2];
    logic [3:0]  sb [2];
    logic [31:0] base, v;
    int n, off, p;
    bit split, illegal;
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]);
    if (illegal) begin
      exp_resp_q.push_back({1'b1, 32'h0});
      exp_cyc_q.push_back(chk_lat ? 1 : 0);
      return;
    end
    n = 1 << f3[1:0];
    off = int'(a[1:0]);
    split = (off + n > 4);
    base = {a[31:2], 2'b00};
    if (w) begin
      wd[0] = 0; wd[1] = 0; sb[0] = 0; sb[1] = 0;
      for (int i = 0; i < 4; i++) begin
        p = off + i;
        wd[p/4][8*(p%4) +: 8] = d[8*i +: 8];
        if (i < n) sb[p/4][p%4] = 1'b1;
      end
      for (int i = 0; i < n; i++) bmem[a + 32'(i)] = d[8*i +: 8];
      exp_q.push_back({1'b1, base, wd[0], sb[0]});
      if (split) exp_q.push_back({1'b1, base + 32'd4, wd[1], sb[1]});
      exp_resp_q.push_back({1'b0, 32'h0});
      exp_cyc_q.push_back(chk_lat ? (split ? 3 : 2) : 0);
    end else begin
      exp_q.push_back({1'b0, base, 32'h0, 4'h0});
      if (split) exp_q.push_back({1'b0, base + 32'd4, 32'h0, 4'h0});
      v = 0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = model_byte(a + 32'(i));
      if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
      exp_resp_q.push_back({1'b0, v});
      exp_cyc_q.push_back(chk_lat ? (split ? 5 : 3) : 0);
    end
  endtask

  // Compare process and memory responder, one pass per cycle after the edge.
  initial begin : compare
    bit          rd_pending;
    int          rd_cnt;
    logic [31:0] rd_word, w_tmp;
    logic [68:0] hd;
    logic [32:0] er;
    int          ec;
    rd_pending = 0;
    rd_cnt = 0;
    rd_word = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rd_pending = 0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        continue;
      end
      check("req_ready", 32'(req_ready), 32'(!busy));
      if (busy) busy_cycles++;
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          fail("mem_extra", $sformatf("mem_valid=1 addr=%h with no beat expected", mem_addr));
        end else begin
          hd = exp_q[0];
          check("beat_write", 32'(mem_write), 32'(hd[68]));
          check("beat_addr", mem_addr, hd[67:36]);
          check("beat_wdata", mem_wdata, hd[35:4]);
          check("beat_wstrb", 32'(mem_wstrb), 32'(hd[3:0]));
        end
      end
      if (resp_valid) begin
        if (!busy || exp_resp_q.size() == 0) begin
          fail("resp_spurious", $sformatf("resp_valid=1 rdata=%h with no request open", resp_rdata));
        end else begin
          er = exp_resp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("resp_rdata", resp_rdata, er[31:0]);
          check("resp_err", 32'(resp_err), 32'(er[32]));
          if (exp_q.size() != 0)
            fail("resp_early", $sformatf("%0d beats still expected", exp_q.size()));
          if (ec != 0) check("latency", 32'(busy_cycles), 32'(ec));
          last_rdata = resp_rdata;
          last_err = resp_err;
          done_cnt++;
          busy = 0;
        end
      end
      if (busy && busy_cycles > 400) begin
        fail("timeout", "no response within 400 cycles");
        busy = 0;
        exp_q.delete();
        exp_resp_q.delete();
        exp_cyc_q.delete();
      end
      if (rd_pending) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = rd_word;
          rd_pending = 0;
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        mem_rvalid = !fast_mode && ($urandom_range(0, 5) == 0);
        mem_rdata = $urandom;
      end
      if (hold_low > 0 && mem_valid) begin
        mem_ready = 1'b0;
        hold_low--;
      end else begin
        mem_ready = fast_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (mem_valid && mem_ready && exp_q.size() != 0) begin
        hd = exp_q.pop_front();
        obs_q.push_back({mem_write, mem_addr, mem_wdata, mem_wstrb});
        if (!hd[68]) begin
          rd_pending = 1;
          rd_cnt = (long_lat > 0) ? long_lat : (fast_mode ? 1 : $urandom_range(1, 3));
          rd_word = wmem_rd(hd[67:36]);
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) begin
              w_tmp = wmem_rd(mem_addr);
              w_tmp[8*b +: 8] = mem_wdata[8*b +: 8];
              wmem[mem_addr] = w_tmp;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 1000) begin
      req_valid = !req_ready && ($urandom_range(0, 2) == 0);
      req_write = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    if (busy) fail("done_timeout", "request never completed");
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit chk_lat, input bit wait_done);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((!req_ready || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      fail("issue_timeout", "req_ready never returned");
      return;
    end
    model_push(w, f3, a, d, chk_lat);
    req_valid = 1'b1;
    req_write = w;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    busy = 1;
    busy_cycles = 0;
    @(negedge clk);
    req_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  logic [68:0] ob;
  logic [2:0]  ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  int          d0;

  initial begin : driver
    logic [2:0]  f3;
    logic        w;
    logic [31:0] a;
    int          guard;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = 0; req_wdata = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    rst_n = 1'b1;

    // Byte store into the top lane.
    obs_q.delete(); d0 = done_cnt;
    issue(1'b1, 3'b000, 32'h1003, 32'h000000AB, 1, 1);
    check("sb_resp_count", 32'(done_cnt - d0), 32'd1);
    check("sb_beats", 32'(obs_q.size()), 32'd1);
    ob = obs_q[0];
    check("sb_addr", ob[67:36], 32'h1000);
    check("sb_wstrb", 32'(ob[3:0]), 32'h8);
    check("sb_wdata", ob[35:4], 32'hAB000000);
    check("sb_rdata", last_rdata, 32'h0);

    // Halfword load, signed then unsigned.
    poke_word(32'h2000, 32'h80011234);
    issue(1'b0, 3'b001, 32'h2002, 32'h0, 1, 1);
    check("lh_rdata", last_rdata, 32'hFFFF8001);
    issue(1'b0, 3'b101, 32'h2002, 32'h0, 1, 1);
    check("lhu_rdata", last_rdata, 32'h00008001);

    // Misaligned word store split into two beats.
    obs_q.delete();
    issue(1'b1, 3'b010, 32'h3001, 32'h11223344, 1, 1);
    check("sw_beats", 32'(obs_q.size()), 32'd2);
    ob = obs_q[0];
    check("sw_b0_addr", ob[67:36], 32'h3000);
    check("sw_b0_wstrb", 32'(ob[3:0]), 32'hE);
    check("sw_b0_wdata", ob[35:4], 32'h22334400);
    ob = obs_q[1];
    check("sw_b1_addr", ob[67:36], 32'h3004);
    check("sw_b1_wstrb", 32'(ob[3:0]), 32'h1);
    check("sw_b1_wdata", ob[35:4], 32'h00000011);

    // Split load wrapping the address space.
    poke_word(32'hFFFFFFFC, 32'hAAAABBBB);
    poke_word(32'h00000000, 32'hCCCCDDDD);
    obs_q.delete();
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 1);
    check("wrap_beats", 32'(obs_q.size()), 32'd2);
    ob = obs_q[1];
    check("wrap_b1_addr", ob[67:36], 32'h00000000);
    check("wrap_rdata", last_rdata, 32'hDDDDAAAA);

    // Illegal codes: error response, no memory traffic.
    obs_q.delete();
    issue(1'b0, 3'b011, 32'h4000, 32'h0, 1, 1);
    check("err_ld_flag", 32'(last_err), 32'h1);
    issue(1'b1, 3'b100, 32'h4000, 32'h55, 1, 1);
    check("err_st_flag", 32'(last_err), 32'h1);
    check("err_beats", 32'(obs_q.size()), 32'd0);

    // Memory stalls the request for five cycles.
    obs_q.delete();
    hold_low = 5;
    issue(1'b0, 3'b010, 32'h600, 32'h0, 0, 1);
    check("stall_beats", 32'(obs_q.size()), 32'd1);
    check("stall_hold_used", 32'(hold_low), 32'd0);

    // Reset while waiting for read data.
    obs_q.delete();
    long_lat = 20;
    issue(1'b0, 3'b010, 32'h500, 32'h0, 0, 0);
    guard = 0;
    while (obs_q.size() == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    busy = 0;
    exp_q.delete(); exp_resp_q.delete(); exp_cyc_q.delete();
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'h1);
    check("mid_rst_mem_valid", 32'(mem_valid), 32'h0);
    check("mid_rst_mem_write", 32'(mem_write), 32'h0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_mem_wdata", mem_wdata, 32'h0);
    check("mid_rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_resp_rdata", resp_rdata, 32'h0);
    check("mid_rst_resp_err", 32'(resp_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    long_lat = 0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    check("mid_rst_no_resp", 32'(done_cnt - d0), 32'd0);
    poke_word(32'h504, 32'h0BADF00D);
    issue(1'b0, 3'b010, 32'h504, 32'h0, 1, 1);
    check("post_rst_lw", last_rdata, 32'h0BADF00D);

    // Randomized traffic with random stalls, read latency and stray rvalid.
    fast_mode = 0;
    for (int k = 0; k < 250; k++) begin
      w = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0)
        f3 = w ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 31));
      issue(w, f3, a, $urandom, 0, 1);
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
